// File: rtl/datapath_unit_if.sv
// datapath_unit_if: control inputs and status outputs of the datapath unit
interface datapath_unit_if;
  logic        WE;
  logic        ALUorM;
  logic [2:0]  ALUCntr;
  logic        ALUSrc2;
  logic [1:0]  RDst3;
  logic [1:0]  RSrc1;
  logic [7:0]  Src2;
  logic [3:0]  ALUFlags;
  logic [7:0]  Result;
  logic [31:0] RegView;
  modport master (
    output WE, ALUorM, ALUCntr, ALUSrc2, RDst3, RSrc1, Src2,
    input  ALUFlags, Result, RegView
  );
  modport slave (
    input  WE, ALUorM, ALUCntr, ALUSrc2, RDst3, RSrc1, Src2,
    output ALUFlags, Result, RegView
  );
endinterface

// File: rtl/datapath_unit.sv
// datapath_unit: 4x8 register file, 8-bit ALU with NZCV flags and a 16x8 constant lookup table
module datapath_unit (
  input  logic            clk,
  input  logic            reset,
  datapath_unit_if.slave  bus
);
  logic [7:0] r_q [4];
  logic [7:0] r_d [4];
  logic [7:0] result_q, result_d;
  logic [3:0] flags_q, flags_d;
  logic [7:0] a, b, y, mem, wb;
  logic [2:0] sh;
  logic [8:0] sum, dif, shl, shr;
  logic       c, v;
  always_comb begin
    a   = r_q[bus.RSrc1];
    b   = bus.ALUSrc2 ? bus.Src2 : r_q[bus.Src2[1:0]];
    sh  = b[2:0];
    sum = {1'b0, a} + {1'b0, b};
    dif = {1'b0, a} - {1'b0, b};
    shl = {1'b0, a} << sh;
    shr = {a, 1'b0} >> sh;
    y   = 8'h00;
    c   = 1'b0;
    v   = 1'b0;
    case (bus.ALUCntr)
      3'b000: begin
        y = sum[7:0];
        c = sum[8];
        v = (a[7] == b[7]) && (y[7] != a[7]);
      end
      3'b001: begin
        y = dif[7:0];
        c = ~dif[8];
        v = (a[7] != b[7]) && (y[7] != a[7]);
      end
      3'b010: y = a & b;
      3'b011: y = a | b;
      3'b100: y = a ^ b;
      3'b101: y = b;
      3'b110: begin
        y = shl[7:0];
        c = shl[8];
      end
      default: begin
        y = shr[8:1];
        c = shr[0];
      end
    endcase
    mem      = {y[3:0], ~y[3:0]};
    wb       = bus.ALUorM ? mem : y;
    flags_d  = {y[7], y == 8'h00, c, v};
    r_d      = r_q;
    r_d[bus.RDst3] = bus.WE ? wb : r_q[bus.RDst3];
    result_d = bus.WE ? wb : result_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q      <= '{default: 8'h00};
      result_q <= 8'h00;
      flags_q  <= 4'h0;
    end else begin
      r_q      <= r_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end
  assign bus.ALUFlags = flags_q;
  assign bus.Result   = result_q;
  assign bus.RegView  = {r_q[3], r_q[2], r_q[1], r_q[0]};
endmodule

// File: tb/tb_datapath_unit.sv
// tb_datapath_unit: table-driven directed vectors plus a back-to-back accumulate sequence
module tb_datapath_unit;
  logic clk = 1'b0;
  logic reset;
  int   n_run = 0;
  int   n_fail = 0;
  datapath_unit_if bus ();
  datapath_unit dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic        rst;
    logic        we;
    logic        aluorm;
    logic [2:0]  op;
    logic        imm;
    logic [1:0]  rd;
    logic [1:0]  rs;
    logic [7:0]  src2;
    logic [31:0] exp_view;
    logic [7:0]  exp_res;
    logic [3:0]  exp_flags;
  } vec_t;
  vec_t vecs [$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic drive(input vec_t v);
    @(negedge clk);
    reset       = v.rst;
    bus.WE      = v.we;
    bus.ALUorM  = v.aluorm;
    bus.ALUCntr = v.op;
    bus.ALUSrc2 = v.imm;
    bus.RDst3   = v.rd;
    bus.RSrc1   = v.rs;
    bus.Src2    = v.src2;
    @(posedge clk);
    #1;
  endtask
  initial begin
    reset = 1'b1; bus.WE = 1'b0; bus.ALUorM = 1'b0; bus.ALUCntr = 3'd0;
    bus.ALUSrc2 = 1'b0; bus.RDst3 = 2'd0; bus.RSrc1 = 2'd0; bus.Src2 = 8'h00;
    //           rst we  m  op    imm rd  rs  src2   view          res    flags
    vecs.push_back('{1, 1, 0, 3'd0, 1, 0, 0, 8'h10, 32'h00000000, 8'h00, 4'b0000});
    vecs.push_back('{0, 1, 0, 3'd5, 1, 1, 0, 8'h7F, 32'h00007F00, 8'h7F, 4'b0000});
    vecs.push_back('{0, 1, 0, 3'd0, 1, 2, 1, 8'h01, 32'h00807F00, 8'h80, 4'b1001});
    vecs.push_back('{0, 1, 0, 3'd5, 1, 1, 0, 8'h05, 32'h00800500, 8'h05, 4'b0000});
    vecs.push_back('{0, 1, 0, 3'd1, 1, 3, 1, 8'h05, 32'h00800500, 8'h00, 4'b0110});
    vecs.push_back('{0, 1, 0, 3'd1, 1, 3, 3, 8'h01, 32'hFF800500, 8'hFF, 4'b1000});
    vecs.push_back('{0, 1, 0, 3'd5, 1, 0, 0, 8'h03, 32'hFF800503, 8'h03, 4'b0000});
    vecs.push_back('{0, 1, 1, 3'd0, 1, 1, 0, 8'h00, 32'hFF803C03, 8'h3C, 4'b0000});
    vecs.push_back('{0, 1, 1, 3'd0, 1, 1, 0, 8'h1C, 32'hFF80F003, 8'hF0, 4'b0000});
    vecs.push_back('{0, 1, 0, 3'd5, 1, 2, 0, 8'h81, 32'hFF81F003, 8'h81, 4'b1000});
    vecs.push_back('{0, 0, 0, 3'd6, 1, 2, 2, 8'h01, 32'hFF81F003, 8'h81, 4'b0010});
    vecs.push_back('{0, 0, 0, 3'd7, 1, 2, 2, 8'h00, 32'hFF81F003, 8'h81, 4'b1000});
    vecs.push_back('{0, 1, 0, 3'd0, 0, 1, 1, 8'h01, 32'hFF81E003, 8'hE0, 4'b1010});
    vecs.push_back('{0, 1, 0, 3'd2, 1, 0, 2, 8'h0F, 32'hFF81E001, 8'h01, 4'b0000});
    vecs.push_back('{0, 1, 0, 3'd3, 1, 0, 0, 8'hF0, 32'hFF81E0F1, 8'hF1, 4'b1000});
    vecs.push_back('{0, 1, 0, 3'd4, 0, 0, 0, 8'h02, 32'hFF81E070, 8'h70, 4'b0000});
    vecs.push_back('{0, 1, 0, 3'd1, 1, 3, 0, 8'h90, 32'hE081E070, 8'hE0, 4'b1001});
    vecs.push_back('{0, 1, 0, 3'd7, 1, 2, 2, 8'h07, 32'hE001E070, 8'h01, 4'b0000});
    vecs.push_back('{0, 1, 0, 3'd6, 1, 1, 1, 8'h03, 32'hE0010070, 8'h00, 4'b0110});
    vecs.push_back('{1, 1, 0, 3'd0, 1, 0, 0, 8'h10, 32'h00000000, 8'h00, 4'b0000});
    vecs.push_back('{0, 1, 0, 3'd0, 1, 0, 0, 8'h10, 32'h00000010, 8'h10, 4'b0000});
    vecs.push_back('{0, 1, 0, 3'd0, 1, 1, 0, 8'hF0, 32'h00000010, 8'h00, 4'b0110});
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      chk($sformatf("v%0d.regview", i), bus.RegView, vecs[i].exp_view);
      chk($sformatf("v%0d.result", i), {24'h0, bus.Result}, {24'h0, vecs[i].exp_res});
      chk($sformatf("v%0d.flags", i), {28'h0, bus.ALUFlags}, {28'h0, vecs[i].exp_flags});
    end
    // back-to-back R0 <- R0 + R0 register-operand accumulate: each step must see last cycle's value
    for (int k = 0; k < 4; k++) begin
      logic [7:0] e;
      e = 8'h10 << (k + 1);
      drive('{0, 1, 0, 3'd0, 0, 0, 0, 8'h00, 32'h0, 8'h0, 4'h0});
      chk($sformatf("acc%0d.r0", k), {24'h0, bus.RegView[7:0]}, {24'h0, e});
      chk($sformatf("acc%0d.result", k), {24'h0, bus.Result}, {24'h0, e});
    end
    // several idle cycles with WE=0 must leave registers and Result untouched
    for (int k = 0; k < 3; k++) begin
      drive('{0, 0, 0, 3'd5, 1, 0, 0, 8'hAA, 32'h0, 8'h0, 4'h0});
      chk($sformatf("hold%0d.regview", k), bus.RegView, 32'h00000000);
      chk($sformatf("hold%0d.result", k), {24'h0, bus.Result}, 32'h00000000);
      chk($sformatf("hold%0d.flags", k), {28'h0, bus.ALUFlags}, 32'h00000008);
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/datapath_unit.md
DATAPATH_UNIT -- requirements
Module: datapath_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  in  1  system clock; all state updates on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 WE  in  1  register-file write enable.
REQ-005 ALUorM  in  1  write-back select: 0 = ALU result, 1 = data-memory read.
REQ-006 ALUCntr  in  3  ALU operation code.
REQ-007 ALUSrc2  in  1  operand-B select: 0 = register, 1 = immediate.
REQ-008 RDst3  in  2  destination register index.
REQ-009 RSrc1  in  2  operand-A register index.
REQ-010 Src2  in  8  immediate value, or operand-B register index in Src2[1:0] when ALUSrc2=0.
REQ-011 ALUFlags  out  4  registered flags {N,Z,C,V}, bit 3 = N, bit 0 = V.
REQ-012 Result  out  8  registered copy of the last value written back.
REQ-013 RegView  out  32  register contents {R3,R2,R1,R0} for display.

Function
REQ-014 The register file SHALL hold four 8-bit registers R0..R3 with combinational reads at RSrc1 and Src2[1:0].
REQ-015 Operand A SHALL be R[RSrc1]; operand B SHALL be Src2 when ALUSrc2=1, else R[Src2[1:0]].
REQ-016 ALU ops SHALL be: 000 ADD A+B, 001 SUB A-B, 010 AND, 011 OR, 100 XOR, 101 MOV (B), 110 SHL A<<B[2:0], 111 SHR logical A>>B[2:0].
REQ-017 All arithmetic SHALL be 8-bit modulo 256; carries beyond bit 7 are reported only through C.
REQ-018 N SHALL be bit 7 of the ALU result, and Z SHALL be 1 iff the ALU result is 8'h00.
REQ-019 For ADD, C = carry out of bit 7, and V = 1 iff the operands share a sign that differs from the result's sign.
REQ-020 For SUB, C = 1 iff A>=B unsigned (no borrow), and V = 1 iff the operands' signs differ and the result's sign differs from A's.
REQ-021 For SHL and SHR, C SHALL be the last bit shifted out (0 when B[2:0]=0), and V SHALL be 0.
REQ-022 For AND, OR, XOR and MOV, C and V SHALL be 0.
REQ-023 The data memory SHALL be a 16x8 read-only table addressed by ALU result[3:0], with mem[i] = {i[3:0], ~i[3:0]}, read combinationally.
REQ-024 The write-back value SHALL be the memory read when ALUorM=1, else the ALU result.
REQ-025 On a rising edge with WE=1, R[RDst3] SHALL take the write-back value and Result SHALL take the same value.
REQ-026 On a rising edge with WE=0, the register file and Result SHALL hold their values.
REQ-027 ALUFlags SHALL be loaded from the current ALU flags on every rising edge, regardless of WE or ALUorM (one-cycle latency).
REQ-028 A read of a register in the same cycle it is being written SHALL return the old value; the new value is visible from the next cycle.
REQ-029 When source and destination registers coincide (e.g. R1 <- R1+R1), the old value SHALL be used as the operand.
REQ-030 RegView SHALL reflect register contents directly, updating in the cycle after a write.

Reset
REQ-031 While reset=1 at a rising edge, R0..R3, Result and ALUFlags SHALL all become 0, overriding WE.
REQ-032 Reset asserted mid-sequence SHALL discard any pending write in that cycle, and operation SHALL resume normally on the first edge with reset=0.

Verification
REQ-033 Reset then idle: reset=1 for one edge with WE=1 -> RegView=32'h0, Result=8'h00, ALUFlags=4'b0000.
REQ-034 Immediate load and add: MOV R1,#8'h7F (WE=1); then ADD R2,R1,#8'h01 -> R2=8'h80, Result=8'h80, ALUFlags=4'b1001 one cycle after the ADD.
REQ-035 Subtract to zero: R1=8'h05; SUB R3,R1,#8'h05 -> R3=8'h00, ALUFlags=4'b0110; then SUB R3,R3,#8'h01 -> R3=8'hFF, ALUFlags=4'b1000.
REQ-036 Memory write-back: MOV R0,#8'h03; ALUorM=1, ADD R1,R0,#8'h00 -> R1=8'h3C; a second access with ALU result 8'h1F -> 8'hF0 (only bits [3:0] address the table).
REQ-037 Shifts and WE=0: R2=8'h81; SHL with B=1, WE=0 -> R2 unchanged, Result unchanged, ALUFlags=4'b0010; SHR with B=0 -> ALUFlags=4'b1000.
REQ-038 Reset mid-operation: reset=1 in the same cycle as WE=1, ADD R0,#8'h10 -> R0=8'h00; the next cycle with reset=0 performs the write normally.
